// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified I/D memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned BUS_ADDR_W = 32;
  localparam int unsigned BUS_DATA_W = 32;
  localparam int unsigned BUS_BE_W   = BUS_DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    REQ_IF,
    RSP_IF,
    REQ_MEM,
    RSP_MEM
  } arb_state_t;

  typedef struct packed {
    logic                  we;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wdata;
    logic [BUS_BE_W-1:0]   be;
  } mem_bus_req_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between fetch and load/store, data first,
// one outstanding access at a time, with stall generation and stale-fetch drop.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = BUS_ADDR_W,
  parameter int unsigned DATA_W = BUS_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_valid_o,
  input  logic                mem_req_i,
  input  logic                mem_we_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  input  logic [DATA_W/8-1:0] mem_be_i,
  output logic [DATA_W-1:0]   mem_rdata_o,
  output logic                mem_valid_o,
  input  logic                flush_i,
  output logic                m_req_o,
  output logic                m_we_o,
  output logic [ADDR_W-1:0]   m_addr_o,
  output logic [DATA_W-1:0]   m_wdata_o,
  output logic [DATA_W/8-1:0] m_be_o,
  input  logic                m_gnt_i,
  input  logic                m_rvalid_i,
  input  logic [DATA_W-1:0]   m_rdata_i,
  output logic                stall_if_o,
  output logic                stall_mem_o
);

  arb_state_t   state_q, state_d;
  mem_bus_req_t bus_q, bus_d;
  logic         m_req_q, m_req_d;
  logic         drop_q, drop_d;

  // State, request bus and stale-fetch flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bus_q   <= '0;
      m_req_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bus_q   <= bus_d;
      m_req_q <= m_req_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state, request capture and response qualification
  always_comb begin
    state_d     = state_q;
    bus_d       = bus_q;
    m_req_d     = m_req_q;
    drop_d      = drop_q;
    if_valid_o  = 1'b0;
    mem_valid_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mem_req_i) begin
          bus_d.we    = mem_we_i;
          bus_d.addr  = BUS_ADDR_W'(mem_addr_i);
          bus_d.wdata = BUS_DATA_W'(mem_wdata_i);
          bus_d.be    = BUS_BE_W'(mem_be_i);
          m_req_d     = 1'b1;
          state_d     = REQ_MEM;
        end else if (if_req_i) begin
          bus_d.we    = 1'b0;
          bus_d.addr  = BUS_ADDR_W'(if_addr_i);
          bus_d.wdata = '0;
          bus_d.be    = '1;
          m_req_d     = 1'b1;
          state_d     = REQ_IF;
        end
      end
      REQ_IF: begin
        if (m_gnt_i) begin
          m_req_d = 1'b0;
          state_d = RSP_IF;
        end
      end
      RSP_IF: begin
        if_valid_o = m_rvalid_i & ~drop_q & ~flush_i;
        if (m_rvalid_i) state_d = IDLE;
      end
      REQ_MEM: begin
        if (m_gnt_i) begin
          m_req_d = 1'b0;
          state_d = RSP_MEM;
        end
      end
      RSP_MEM: begin
        mem_valid_o = m_rvalid_i;
        if (m_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A fetch made stale by a taken branch stays suppressed until the port idles
    if (state_d == IDLE) begin
      drop_d = 1'b0;
    end else if (flush_i && (state_q == REQ_IF || state_q == RSP_IF)) begin
      drop_d = 1'b1;
    end
  end

  assign m_req_o     = m_req_q;
  assign m_we_o      = bus_q.we;
  assign m_addr_o    = ADDR_W'(bus_q.addr);
  assign m_wdata_o   = DATA_W'(bus_q.wdata);
  assign m_be_o      = (DATA_W/8)'(bus_q.be);

  assign if_rdata_o  = m_rdata_i;
  assign mem_rdata_o = m_rdata_i;

  assign stall_mem_o = mem_req_i & ~mem_valid_o;
  assign stall_if_o  = stall_mem_o | (if_req_i & ~if_valid_o);

endmodule
